// File: rtl/softmax_job_scheduler_pkg.sv
// Shared types and defaults for the softmax job scheduler: job record layout,
// scheduler FSM states and softmax engine timing limits.
package softmax_job_scheduler_pkg;

    localparam int unsigned NUM_OF_NODES      = 4;
    localparam int unsigned DATA_WIDTH        = 8;
    localparam int unsigned ALPHA_DATA_WIDTH  = 12;
    localparam int unsigned NUM_NODE_WIDTH    = 3;
    localparam int unsigned SM_MIN_LAT        = 8;
    localparam int unsigned SM_TIMEOUT_CYCLES = 1024;

    localparam logic [NUM_NODE_WIDTH-1:0] MAX_NODES = NUM_NODE_WIDTH'(NUM_OF_NODES);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } sched_state_e;

    typedef struct packed {
        logic [NUM_NODE_WIDTH-1:0]          num_nodes;
        logic [NUM_OF_NODES*DATA_WIDTH-1:0] coef;
    } sm_job_t;

    localparam int unsigned JOB_WIDTH = $bits(sm_job_t);

    // A job is only worth running if it names between 1 and NUM_OF_NODES entries.
    function automatic logic legal_len(input logic [NUM_NODE_WIDTH-1:0] n);
        return (n != '0) && (n <= MAX_NODES);
    endfunction

endpackage

// File: rtl/softmax_job_scheduler_fifo.sv
// Synchronous job queue for the softmax scheduler; head entry is visible on
// rdata whenever the queue is non-empty.
module softmax_job_scheduler_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/softmax_job_scheduler.sv
// Feeds queued attention-coefficient jobs one at a time into the shared softmax
// engine and parks each result in a valid/ready register for aggregation.
module softmax_job_scheduler
    import softmax_job_scheduler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned MIN_LAT        = SM_MIN_LAT,
    parameter int unsigned TIMEOUT_CYCLES = SM_TIMEOUT_CYCLES,
    parameter int unsigned JOB_CNT_WIDTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable_i,
    input  logic                                   clear_i,
    input  logic [JOB_CNT_WIDTH-1:0]               total_jobs_i,
    input  logic                                   coef_valid_i,
    output logic                                   coef_ready_o,
    input  logic [NUM_OF_NODES*DATA_WIDTH-1:0]     coef_i,
    input  logic [NUM_NODE_WIDTH-1:0]              num_nodes_i,
    output logic                                   sm_valid_o,
    output logic [NUM_OF_NODES*DATA_WIDTH-1:0]     sm_coef_o,
    output logic [NUM_NODE_WIDTH-1:0]              sm_num_of_nodes_o,
    input  logic                                   sm_ready_i,
    input  logic [NUM_OF_NODES*ALPHA_DATA_WIDTH-1:0] alpha_i,
    output logic                                   alpha_valid_o,
    input  logic                                   alpha_ready_i,
    output logic [NUM_OF_NODES*ALPHA_DATA_WIDTH-1:0] alpha_o,
    output logic [NUM_NODE_WIDTH-1:0]              alpha_num_of_nodes_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [JOB_CNT_WIDTH-1:0]               job_cnt_o,
    output logic                                   len_err_o,
    output logic                                   timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] MIN_LAT_C = CW'(MIN_LAT);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);

    sched_state_e state;
    sched_state_e state_next;

    logic          launch;
    logic          capture;
    logic          expire;
    logic          in_service;
    logic          len_ok;
    logic          accept;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    sm_job_t       fifo_wdata;
    sm_job_t       fifo_rdata;
    logic [CW-1:0] wait_cnt;

    // in_service keeps coef_ready_o low through reset and releases it one cycle later.
    assign coef_ready_o = in_service && !fifo_full;
    assign len_ok       = legal_len(num_nodes_i);
    assign accept       = coef_valid_i && coef_ready_o;
    assign push         = accept && len_ok;
    assign fifo_wdata   = {num_nodes_i, coef_i};

    assign sm_valid_o = (state == LAUNCH);
    assign busy_o     = (state != IDLE) || !fifo_empty;

    softmax_job_scheduler_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (JOB_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (launch),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && !fifo_empty && (!alpha_valid_o || alpha_ready_i)) begin
                    launch     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                // Early completions are stale handshakes from the previous job.
                if (sm_ready_i && (wait_cnt >= MIN_LAT_C)) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == TIMEOUT_C) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_service           <= 1'b0;
            wait_cnt             <= '0;
            sm_coef_o            <= '0;
            sm_num_of_nodes_o    <= '0;
            alpha_valid_o        <= 1'b0;
            alpha_o              <= '0;
            alpha_num_of_nodes_o <= '0;
            done_o               <= 1'b0;
            job_cnt_o            <= '0;
            len_err_o            <= 1'b0;
            timeout_o            <= 1'b0;
        end else begin
            in_service <= 1'b1;

            if (launch) begin
                sm_coef_o         <= fifo_rdata.coef;
                sm_num_of_nodes_o <= fifo_rdata.num_nodes;
            end

            if (state == LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (capture) begin
                alpha_valid_o        <= 1'b1;
                alpha_o              <= alpha_i;
                alpha_num_of_nodes_o <= sm_num_of_nodes_o;
            end else if (alpha_ready_i) begin
                alpha_valid_o <= 1'b0;
            end

            done_o <= capture && (total_jobs_i != '0) && (job_cnt_o + 1'b1 == total_jobs_i);

            if (clear_i) begin
                job_cnt_o <= '0;
                len_err_o <= 1'b0;
                timeout_o <= 1'b0;
            end else begin
                if (capture) begin
                    if ((total_jobs_i != '0) && (job_cnt_o + 1'b1 == total_jobs_i)) begin
                        job_cnt_o <= '0;
                    end else begin
                        job_cnt_o <= job_cnt_o + 1'b1;
                    end
                end
                if (accept && !len_ok) begin
                    len_err_o <= 1'b1;
                end
                if (expire) begin
                    timeout_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_softmax_job_scheduler.sv
// Scenario bench for softmax_job_scheduler against a queue-based job model.
module tb_softmax_job_scheduler;
    import softmax_job_scheduler_pkg::*;

    localparam int MINL = 8;
    localparam int TMO  = 64;
    localparam int CNTW = 16;
    localparam int CV   = NUM_OF_NODES * DATA_WIDTH;
    localparam int AV   = NUM_OF_NODES * ALPHA_DATA_WIDTH;
    localparam int NW   = NUM_NODE_WIDTH;

    typedef struct packed {
        logic [NW-1:0] n;
        logic [CV-1:0] c;
    } job_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable_i = 1'b0;
    logic            clear_i = 1'b0;
    logic [CNTW-1:0] total_jobs_i = '0;
    logic            coef_valid_i = 1'b0;
    logic            coef_ready_o;
    logic [CV-1:0]   coef_i = '0;
    logic [NW-1:0]   num_nodes_i = '0;
    logic            sm_valid_o;
    logic [CV-1:0]   sm_coef_o;
    logic [NW-1:0]   sm_num_of_nodes_o;
    logic            sm_ready_i = 1'b0;
    logic [AV-1:0]   alpha_i = '0;
    logic            alpha_valid_o;
    logic            alpha_ready_i = 1'b1;
    logic [AV-1:0]   alpha_o;
    logic [NW-1:0]   alpha_num_of_nodes_o;
    logic            busy_o;
    logic            done_o;
    logic [CNTW-1:0] job_cnt_o;
    logic            len_err_o;
    logic            timeout_o;

    int   checks = 0;
    int   failures = 0;
    job_t exp_q[$];
    int   exp_cnt = 0;
    logic exp_len = 1'b0;
    logic exp_to = 1'b0;

    softmax_job_scheduler #(
        .FIFO_DEPTH     (2),
        .MIN_LAT        (MINL),
        .TIMEOUT_CYCLES (TMO),
        .JOB_CNT_WIDTH  (CNTW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable_i             (enable_i),
        .clear_i              (clear_i),
        .total_jobs_i         (total_jobs_i),
        .coef_valid_i         (coef_valid_i),
        .coef_ready_o         (coef_ready_o),
        .coef_i               (coef_i),
        .num_nodes_i          (num_nodes_i),
        .sm_valid_o           (sm_valid_o),
        .sm_coef_o            (sm_coef_o),
        .sm_num_of_nodes_o    (sm_num_of_nodes_o),
        .sm_ready_i           (sm_ready_i),
        .alpha_i              (alpha_i),
        .alpha_valid_o        (alpha_valid_o),
        .alpha_ready_i        (alpha_ready_i),
        .alpha_o              (alpha_o),
        .alpha_num_of_nodes_o (alpha_num_of_nodes_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .job_cnt_o            (job_cnt_o),
        .len_err_o            (len_err_o),
        .timeout_o            (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CV-1:0] rand_coef();
        logic [CV-1:0] v;
        for (int i = 0; i < NUM_OF_NODES; i++) v[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
        return v;
    endfunction

    function automatic logic [AV-1:0] rand_alpha();
        logic [AV-1:0] v;
        for (int i = 0; i < NUM_OF_NODES; i++) v[i*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH] = ALPHA_DATA_WIDTH'($urandom);
        return v;
    endfunction

    task automatic enqueue(input logic [NW-1:0] n, input logic [CV-1:0] c);
        bit hs = 0;
        coef_valid_i = 1'b1;
        coef_i       = c;
        num_nodes_i  = n;
        for (int i = 0; i < 60 && !hs; i++) begin
            if (coef_ready_o === 1'b1) hs = 1;
            tick();
        end
        coef_valid_i = 1'b0;
        checks++;
        if (!hs) begin
            failures++;
            $display("FAIL enqueue_handshake got=no_ready exp=ready_within_60");
        end else if (int'(n) >= 1 && int'(n) <= NUM_OF_NODES) begin
            exp_q.push_back('{n: n, c: c});
        end else begin
            exp_len = 1'b1;
        end
    endtask

    task automatic wait_launch(output job_t j);
        bit found = 0;
        j = '0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (sm_valid_o === 1'b1) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL launch_seen got=none exp=sm_valid_o_pulse");
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL launch_expected got=launch exp=no_job_queued");
        end else begin
            j = exp_q.pop_front();
        end
        checks++;
        if (sm_num_of_nodes_o !== j.n || sm_coef_o !== j.c) begin
            failures++;
            $display("FAIL launch_job got=%0d/%h exp=%0d/%h", sm_num_of_nodes_o, sm_coef_o, j.n, j.c);
        end
        tick();
        checks++;
        if (sm_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL launch_single_pulse got=%b exp=0", sm_valid_o);
        end
    endtask

    // mode 0: random early pulses then one at MIN_LAT+extra; 1: toggles from cycle 1; 2: never.
    task automatic run_wait(input int mode, input job_t j, output logic [AV-1:0] cap_alpha);
        logic pat [0:TMO];
        int   extra = $urandom_range(0, 4);
        int   cap = -1;
        int   end_k;
        logic exp_done = 1'b0;
        logic [AV-1:0] a = '0;
        for (int k = 0; k <= TMO; k++) begin
            case (mode)
                0:       pat[k] = (k < MINL) ? 1'($urandom_range(0, 1)) : (k == MINL + extra);
                1:       pat[k] = (k % 2 == 1);
                default: pat[k] = 1'b0;
            endcase
        end
        for (int k = 0; k <= TMO; k++) begin
            if (pat[k] && k >= MINL) begin
                cap = k;
                break;
            end
        end
        end_k = (cap >= 0) ? cap : TMO;
        for (int k = 0; k <= end_k; k++) begin
            sm_ready_i = pat[k];
            a          = rand_alpha();
            alpha_i    = a;
            checks++;
            if (sm_valid_o !== 1'b0 || sm_num_of_nodes_o !== j.n || sm_coef_o !== j.c) begin
                failures++;
                $display("FAIL wait_hold k=%0d got=%b/%0d/%h exp=0/%0d/%h", k, sm_valid_o, sm_num_of_nodes_o, sm_coef_o, j.n, j.c);
            end
            checks++;
            if (alpha_valid_o !== 1'b0 || done_o !== 1'b0 || job_cnt_o !== CNTW'(exp_cnt) || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL wait_no_capture k=%0d got=v%b d%b c%0d b%b exp=v0 d0 c%0d b1", k, alpha_valid_o, done_o, job_cnt_o, busy_o, exp_cnt);
            end
            tick();
        end
        sm_ready_i = 1'b0;
        cap_alpha  = a;
        if (cap >= 0) begin
            exp_cnt++;
            if (total_jobs_i != '0 && exp_cnt == int'(total_jobs_i)) begin
                exp_done = 1'b1;
                exp_cnt  = 0;
            end
            checks++;
            if (alpha_valid_o !== 1'b1 || alpha_o !== a || alpha_num_of_nodes_o !== j.n) begin
                failures++;
                $display("FAIL capture got=%b/%h/%0d exp=1/%h/%0d", alpha_valid_o, alpha_o, alpha_num_of_nodes_o, a, j.n);
            end
            checks++;
            if (job_cnt_o !== CNTW'(exp_cnt) || done_o !== exp_done) begin
                failures++;
                $display("FAIL capture_count got=%0d/%b exp=%0d/%b", job_cnt_o, done_o, exp_cnt, exp_done);
            end
        end else begin
            exp_to = 1'b1;
            checks++;
            if (alpha_valid_o !== 1'b0 || job_cnt_o !== CNTW'(exp_cnt)) begin
                failures++;
                $display("FAIL timeout_no_capture got=%b/%0d exp=0/%0d", alpha_valid_o, job_cnt_o, exp_cnt);
            end
        end
        checks++;
        if (timeout_o !== exp_to || len_err_o !== exp_len || sm_num_of_nodes_o !== j.n) begin
            failures++;
            $display("FAIL post_job_flags got=to%b le%b n%0d exp=to%b le%b n%0d", timeout_o, len_err_o, sm_num_of_nodes_o, exp_to, exp_len, j.n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({sm_valid_o, sm_coef_o, sm_num_of_nodes_o, alpha_valid_o, alpha_o, alpha_num_of_nodes_o,
             busy_o, done_o, job_cnt_o, len_err_o, timeout_o, coef_ready_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=nonzero exp=all_zero");
        end
        rst = 1'b0;
        checks++;
        if (coef_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_during_release got=%b exp=0", coef_ready_o);
        end
        tick();
        checks++;
        if (coef_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", coef_ready_o);
        end
    endtask

    task automatic test_single_job();
        job_t j;
        logic [AV-1:0] a;
        logic [CV-1:0] c;
        for (int i = 0; i < NUM_OF_NODES; i++) c[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i);
        enable_i      = 1'b1;
        alpha_ready_i = 1'b1;
        enqueue(NW'(4), c);
        wait_launch(j);
        run_wait(0, j, a);
        checks++;
        if (job_cnt_o !== CNTW'(1)) begin
            failures++;
            $display("FAIL single_job_cnt got=%0d exp=1", job_cnt_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        job_t j1, j2, j3, g;
        logic [AV-1:0] a;
        j1 = '{n: NW'($urandom_range(1, 4)), c: rand_coef()};
        j2 = '{n: NW'($urandom_range(1, 4)), c: rand_coef()};
        j3 = '{n: NW'($urandom_range(1, 4)), c: rand_coef()};
        enable_i = 1'b0;
        enqueue(j1.n, j1.c);
        enqueue(j2.n, j2.c);
        checks++;
        if (coef_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL fifo_full_ready got=%b/%b exp=0/1", coef_ready_o, busy_o);
        end
        coef_valid_i = 1'b1;
        coef_i       = j3.c;
        num_nodes_i  = j3.n;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (coef_ready_o !== 1'b0 || sm_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL full_no_bypass got=%b/%b exp=0/0", coef_ready_o, sm_valid_o);
            end
        end
        alpha_ready_i = 1'b0;
        enable_i      = 1'b1;
        wait_launch(g);
        coef_valid_i = 1'b0;
        exp_q.push_back(j3);
        checks++;
        if (g !== j1 || coef_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first got=%0d/%b exp=%0d/0", g.n, coef_ready_o, j1.n);
        end
        run_wait(0, g, a);
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (sm_valid_o !== 1'b0 || alpha_valid_o !== 1'b1 || alpha_o !== a) begin
                failures++;
                $display("FAIL backpressure_hold got=%b/%b/%h exp=0/1/%h", sm_valid_o, alpha_valid_o, alpha_o, a);
            end
        end
        alpha_ready_i = 1'b1;
        wait_launch(g);
        run_wait(0, g, a);
        wait_launch(g);
        run_wait($urandom_range(0, 1), g, a);
        checks++;
        if (busy_o !== 1'b0 || coef_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drained got=%b/%b exp=0/1", busy_o, coef_ready_o);
        end
        tick();
    endtask

    task automatic test_one_node_toggle();
        job_t j;
        logic [AV-1:0] a;
        enqueue(NW'(1), rand_coef());
        wait_launch(j);
        run_wait(1, j, a);
        tick();
    endtask

    task automatic test_timeout();
        job_t j;
        logic [AV-1:0] a;
        enqueue(NW'($urandom_range(1, 4)), rand_coef());
        wait_launch(j);
        run_wait(2, j, a);
        checks++;
        if (busy_o !== 1'b0 || sm_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle got=%b/%b exp=0/0", busy_o, sm_valid_o);
        end
        enqueue(NW'($urandom_range(1, 4)), rand_coef());
        wait_launch(j);
        run_wait(0, j, a);
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_cnt = 0;
        exp_to  = 1'b0;
        exp_len = 1'b0;
        checks++;
        if (job_cnt_o !== '0 || timeout_o !== 1'b0 || len_err_o !== 1'b0) begin
            failures++;
            $display("FAIL clear got=%0d/%b/%b exp=0/0/0", job_cnt_o, timeout_o, len_err_o);
        end
    endtask

    task automatic test_len_err();
        job_t j;
        logic [AV-1:0] a;
        total_jobs_i = CNTW'(1);
        enqueue(NW'(0), rand_coef());
        checks++;
        if (len_err_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL len_zero_drop got=%b/%b exp=1/0", len_err_o, busy_o);
        end
        enqueue(NW'(NUM_OF_NODES + 1), rand_coef());
        checks++;
        if (len_err_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL len_over_drop got=%b/%b exp=1/0", len_err_o, busy_o);
        end
        enqueue(NW'(2), rand_coef());
        wait_launch(j);
        run_wait(0, j, a);
        tick();
        checks++;
        if (done_o !== 1'b0 || job_cnt_o !== '0) begin
            failures++;
            $display("FAIL done_one_cycle got=%b/%0d exp=0/0", done_o, job_cnt_o);
        end
        total_jobs_i = '0;
    endtask

    task automatic test_random();
        job_t j;
        job_t ja, jb;
        logic [AV-1:0] a;
        for (int i = 0; i < 6; i++) begin
            enqueue(NW'($urandom_range(1, 4)), rand_coef());
            wait_launch(j);
            run_wait($urandom_range(0, 1), j, a);
            tick();
        end
        ja = '{n: NW'($urandom_range(1, 4)), c: rand_coef()};
        jb = '{n: NW'($urandom_range(1, 4)), c: rand_coef()};
        enable_i = 1'b0;
        enqueue(ja.n, ja.c);
        enqueue(jb.n, jb.c);
        enable_i = 1'b1;
        wait_launch(j);
        enable_i = 1'b0;
        run_wait(0, j, a);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sm_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL disabled_hold got=%b/%b exp=0/1", sm_valid_o, busy_o);
            end
        end
        enable_i = 1'b1;
        wait_launch(j);
        checks++;
        if (j !== jb) begin
            failures++;
            $display("FAIL resume_order got=%0d/%h exp=%0d/%h", j.n, j.c, jb.n, jb.c);
        end
        run_wait(0, j, a);
        tick();
    endtask

    task automatic test_reset_in_wait();
        job_t j;
        logic [AV-1:0] a;
        enable_i = 1'b0;
        enqueue(NW'($urandom_range(1, 4)), rand_coef());
        enqueue(NW'($urandom_range(1, 4)), rand_coef());
        enable_i = 1'b1;
        wait_launch(j);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({sm_valid_o, sm_coef_o, sm_num_of_nodes_o, alpha_valid_o, alpha_o, alpha_num_of_nodes_o,
             busy_o, done_o, job_cnt_o, len_err_o, timeout_o, coef_ready_o} !== '0) begin
            failures++;
            $display("FAIL reset_in_wait got=nonzero exp=all_zero");
        end
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        exp_len = 1'b0;
        exp_to  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sm_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL fifo_flushed got=%b/%b exp=0/0", sm_valid_o, busy_o);
            end
        end
        enqueue(NW'($urandom_range(1, 4)), rand_coef());
        wait_launch(j);
        run_wait(0, j, a);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_one_node_toggle();
        test_timeout();
        test_len_err();
        test_random();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
